// File: rtl/conv_mac_engine.sv
// -----------------------------------------------------------------------------
// conv_mac_engine
//   Sequential single-MAC 3x3 convolution over a 4x4 unsigned input map,
//   producing the 2x2 "valid" output map. It performs one multiply-accumulate
//   per cycle, so one convolution takes 36 cycles (4 outputs x 9 taps).
//   This block is the responder side of the controller's weight_load /
//   start / done handshake.
//
// Ports
//   clk                       in   rising-edge clock
//   rst                       in   asynchronous reset, active-high
//   weight_load               in   1-cycle pulse: latch w_11..w_33 (IDLE only)
//   start                     in   1-cycle pulse: latch in_11..in_44 and run
//   w_11..w_33                in   kernel, w_rc = row r, col c (DW each)
//   in_11..in_44              in   input map, in_rc = row r, col c (DW each)
//   conv_out_11..conv_out_22  out  saturated results; out_rc is the window
//                                  whose top-left pixel is in_rc
//   busy                      out  high while a convolution is in progress
//   done                      out  1-cycle completion pulse
// -----------------------------------------------------------------------------
module conv_mac_engine #(
  parameter int DW    = 8,
  parameter int ACC_W = 20   // must be >= 2*DW+4 to hold nine full-scale products
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          weight_load,
  input  logic          start,
  input  logic [DW-1:0] w_11, w_12, w_13,
  input  logic [DW-1:0] w_21, w_22, w_23,
  input  logic [DW-1:0] w_31, w_32, w_33,
  input  logic [DW-1:0] in_11, in_12, in_13, in_14,
  input  logic [DW-1:0] in_21, in_22, in_23, in_24,
  input  logic [DW-1:0] in_31, in_32, in_33, in_34,
  input  logic [DW-1:0] in_41, in_42, in_43, in_44,
  output logic [DW-1:0] conv_out_11,
  output logic [DW-1:0] conv_out_12,
  output logic [DW-1:0] conv_out_21,
  output logic [DW-1:0] conv_out_22,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DW) - 1);

  // Port bundles in row-major order, so they can be latched as whole arrays.
  logic [DW-1:0] w_port  [9];
  logic [DW-1:0] in_port [16];

  assign w_port  = '{w_11, w_12, w_13, w_21, w_22, w_23, w_31, w_32, w_33};
  assign in_port = '{in_11, in_12, in_13, in_14, in_21, in_22, in_23, in_24,
                     in_31, in_32, in_33, in_34, in_41, in_42, in_43, in_44};

  state_t          state_q, state_d;
  logic [DW-1:0]   w_q       [9];
  logic [DW-1:0]   w_d       [9];
  logic [DW-1:0]   in_q      [16];
  logic [DW-1:0]   in_d      [16];
  logic [DW-1:0]   conv_q    [4];
  logic [DW-1:0]   conv_d    [4];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]      tap_q, tap_d;
  logic [1:0]      out_idx_q, out_idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // ---------------------------------------------------------------------------
  // MAC datapath: select the pixel/weight pair for the current tap.
  // ---------------------------------------------------------------------------
  logic [1:0]        kr, kc;
  logic [1:0]        row, col;
  logic [DW-1:0]     pix, wt;
  logic [2*DW-1:0]   prod;
  logic [ACC_W-1:0]  sum;
  logic [DW-1:0]     sat_val;
  logic              last_tap, last_out;

  // NOTE: every signal written in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    kr = 2'd0;
    kc = 2'd0;
    case (tap_q)
      4'd0: begin kr = 2'd0; kc = 2'd0; end
      4'd1: begin kr = 2'd0; kc = 2'd1; end
      4'd2: begin kr = 2'd0; kc = 2'd2; end
      4'd3: begin kr = 2'd1; kc = 2'd0; end
      4'd4: begin kr = 2'd1; kc = 2'd1; end
      4'd5: begin kr = 2'd1; kc = 2'd2; end
      4'd6: begin kr = 2'd2; kc = 2'd0; end
      4'd7: begin kr = 2'd2; kc = 2'd1; end
      4'd8: begin kr = 2'd2; kc = 2'd2; end
      default: ;
    endcase
  end

  // Window origin is (out_idx[1], out_idx[0]); rows/cols never exceed 3.
  assign row      = {1'b0, out_idx_q[1]} + kr;
  assign col      = {1'b0, out_idx_q[0]} + kc;
  assign pix      = in_q[{row, col}];
  assign wt       = w_q[tap_q];
  assign prod     = pix * wt;
  assign sum      = acc_q + ACC_W'(prod);
  assign sat_val  = (sum > SAT_MAX) ? {DW{1'b1}} : sum[DW-1:0];
  assign last_tap = (tap_q == 4'd8);
  assign last_out = (out_idx_q == 2'd3);

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_tap && last_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_d       = w_q;
    in_d      = in_q;
    conv_d    = conv_q;
    acc_d     = acc_q;
    tap_d     = tap_q;
    out_idx_d = out_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;   // done is a single-cycle pulse

    if (state_q == IDLE) begin
      // Load and start in the same cycle are both honoured; the run then
      // reads the freshly loaded weights from w_q on the following edges.
      if (weight_load) w_d = w_port;
      if (start) begin
        in_d      = in_port;
        acc_d     = '0;
        tap_d     = 4'd0;
        out_idx_d = 2'd0;
        busy_d    = 1'b1;
      end
    end else begin
      // weight_load/start are deliberately ignored here: operands are frozen.
      acc_d = sum;
      tap_d = tap_q + 4'd1;
      if (last_tap) begin
        conv_d[out_idx_q] = sat_val;
        acc_d             = '0;
        tap_d             = 4'd0;
        out_idx_d         = out_idx_q + 2'd1;
        if (last_out) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers. The weight/input/result arrays are reset too: a start
  // without a prior weight_load must compute with all-zero weights, and the
  // outputs must read zero after reset.
  // NOTE: resetting register arrays is intentional here; it is a functional
  // requirement of the block, not a default habit for storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++)  w_q[i]    <= '0;
      for (int i = 0; i < 16; i++) in_q[i]   <= '0;
      for (int i = 0; i < 4; i++)  conv_q[i] <= '0;
      acc_q     <= '0;
      tap_q     <= '0;
      out_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      w_q       <= w_d;
      in_q      <= in_d;
      conv_q    <= conv_d;
      acc_q     <= acc_d;
      tap_q     <= tap_d;
      out_idx_q <= out_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (all registered, so glitch-free at the controller)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = busy_q;
    done        = done_q;
    conv_out_11 = conv_q[0];
    conv_out_12 = conv_q[1];
    conv_out_21 = conv_q[2];
    conv_out_22 = conv_q[3];
  end

endmodule
